// File: rtl/piso_mux_ctrl.sv
// Parallel-in/serial-out sequencer for mux_4_1: latches a 4-bit word and steps sel through channels 0..3.
// Optional macro PISO_AUTO_RELOAD_EN accepts the next word in the final dwell cycle for zero-gap streaming.
module piso_mux_ctrl #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    output logic       load_ready,
    output logic       i0,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       sel0,
    output logic       sel1,
    output logic       active,
    output logic       last,
    output logic       done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] DWELL_LAST = 3'(DWELL - 1);

    state_t     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic       active_q, active_d;
    logic       last_q, last_d;
    logic       done_q, done_d;
    logic       xfer;

    // ready is a registered decode of state; rst only masks it so nothing is accepted during reset
    assign load_ready = ready_q & ~rst;
    assign xfer       = load_valid & load_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SHIFT;
                    data_d  = load_data;
                    sel_d   = 2'd0;
                    cnt_d   = 3'd0;
                end
            end
            SHIFT: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = 3'd0;
                    if (sel_q == 2'd3) begin
                        done_d = 1'b1;
                        sel_d  = 2'd0;
`ifdef PISO_AUTO_RELOAD_EN
                        if (xfer) begin
                            data_d = load_data;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d == SHIFT);
        last_d   = (state_d == SHIFT) && (sel_d == 2'd3);
`ifdef PISO_AUTO_RELOAD_EN
        ready_d  = (state_d == IDLE) ||
                   ((sel_d == 2'd3) && (cnt_d == DWELL_LAST));
`else
        ready_d  = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= 4'd0;
            sel_q    <= 2'd0;
            cnt_q    <= 3'd0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign i0     = data_q[0];
    assign i1     = data_q[1];
    assign i2     = data_q[2];
    assign i3     = data_q[3];
    assign sel0   = sel_q[0];
    assign sel1   = sel_q[1];
    assign active = active_q;
    assign last   = last_q;
    assign done   = done_q;

endmodule

// File: tb/tb_piso_mux_ctrl.sv
// Randomized bench for piso_mux_ctrl: two instances (DWELL=1 and DWELL=3) against a cycle-position reference model.
module tb_piso_mux_ctrl;

`ifdef PISO_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] lv, lr, i0, i1, i2, i3, s0, s1, act, lst, dn;
    logic [3:0] ld0, ld1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_mux_ctrl #(.DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld0), .load_ready(lr[0]),
        .i0(i0[0]), .i1(i1[0]), .i2(i2[0]), .i3(i3[0]), .sel0(s0[0]), .sel1(s1[0]),
        .active(act[0]), .last(lst[0]), .done(dn[0])
    );

    piso_mux_ctrl #(.DWELL(3)) u_d3 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld1), .load_ready(lr[1]),
        .i0(i0[1]), .i1(i1[1]), .i2(i2[1]), .i3(i3[1]), .sel0(s0[1]), .sel1(s1[1]),
        .active(act[1]), .last(lst[1]), .done(dn[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a word is a run of 4*DWELL cycles; position t within it gives the channel as t/DWELL.
    int         dw [2] = '{1, 3};
    bit         m_busy [2];
    int         m_t    [2];
    logic [3:0] m_word [2];
    bit         m_done [2];
    int         words_done [2];

    initial begin
        int rst_hold = 0;
        rst = 1'b1;
        lv  = 2'b00;
        ld0 = 4'd0;
        ld1 = 4'd0;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_t[k] = 0; m_word[k] = 4'd0; m_done[k] = 0; words_done[k] = 0;
        end
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                string p;
                int    ch;
                p  = (k == 0) ? "d1" : "d3";
                ch = m_busy[k] ? (m_t[k] / dw[k]) : 0;
                check({p, "_word"}, {28'd0, i3[k], i2[k], i1[k], i0[k]}, {28'd0, m_word[k]});
                check({p, "_sel"}, {30'd0, s1[k], s0[k]}, ch);
                check({p, "_active"}, {31'd0, act[k]}, {31'd0, m_busy[k]});
                check({p, "_last"}, {31'd0, lst[k]}, {31'd0, (m_busy[k] && ch == 3)});
                check({p, "_done"}, {31'd0, dn[k]}, {31'd0, m_done[k]});
                check({p, "_out"}, {31'd0, (s1[k] ? (s0[k] ? i3[k] : i2[k]) : (s0[k] ? i1[k] : i0[k]))},
                      {31'd0, m_word[k][ch]});
            end

            if (rst_hold > 0) begin
                rst = 1'b1;
                rst_hold--;
            end else if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                rst_hold = $urandom_range(0, 1);
            end else begin
                rst = 1'b0;
            end
            lv[0] = ($urandom_range(0, 3) != 0);
            lv[1] = ($urandom_range(0, 3) != 0);
            ld0   = 4'($urandom);
            ld1   = 4'($urandom);

            #1;
            for (int k = 0; k < 2; k++) begin
                bit         rdy, fin;
                logic [3:0] d;
                d   = (k == 0) ? ld0 : ld1;
                fin = m_busy[k] && (m_t[k] == 4 * dw[k] - 1);
                rdy = !rst && (!m_busy[k] || (AUTO && fin));
                check((k == 0) ? "d1_ready" : "d3_ready", {31'd0, lr[k]}, {31'd0, rdy});
                if (rst) begin
                    m_busy[k] = 0; m_t[k] = 0; m_word[k] = 4'd0; m_done[k] = 0;
                end else begin
                    m_done[k] = fin;
                    if (fin) words_done[k]++;
                    if (rdy && lv[k]) begin
                        m_busy[k] = 1; m_t[k] = 0; m_word[k] = d;
                    end else if (fin) begin
                        m_busy[k] = 0; m_t[k] = 0;
                    end else if (m_busy[k]) begin
                        m_t[k]++;
                    end
                end
            end
        end

        // The run must have carried words all the way through on both instances.
        check("d1_words_seen", {31'd0, (words_done[0] > 10)}, 32'd1);
        check("d3_words_seen", {31'd0, (words_done[1] > 10)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_mux_ctrl.md
PISO_MUX_CTRL -- requirements
Module: piso_mux_ctrl

Purpose: upstream sequencer for mux_4_1. Accepts a 4-bit word over a valid/ready handshake, holds it on i0..i3, and steps sel1/sel0 through all four channels so the mux emits the word serially on out.

Interface
REQ-001 Parameter DWELL, default 1, clock cycles each channel is held (legal 1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 load_valid  input  1  upstream word available.
REQ-005 load_data  input  4  word to serialise; bit k drives channel k.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 i0, i1, i2, i3  output  1 each  registered data bits to mux (i0=load_data[0] ... i3=load_data[3]).
REQ-008 sel0, sel1  output  1 each  registered channel select; channel index = {sel1,sel0}, sel0 is LSB.
REQ-009 active  output  1  high while a word is being sequenced.
REQ-010 last  output  1  high while active and channel index = 3.
REQ-011 done  output  1  one-cycle pulse after the final cycle of channel 3.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 A transfer SHALL occur on a rising edge where load_valid=1 and load_ready=1.
REQ-014 In IDLE, load_ready SHALL be 1, active 0, sel 00, and i0..i3 SHALL hold the last accepted word.
REQ-015 On a transfer from IDLE, the next cycle SHALL show: state SHIFT, i0..i3 = load_data, sel 00, active 1.
REQ-016 In SHIFT, each channel SHALL be held for exactly DWELL cycles, then advance 00->01->10->11. A 3-bit dwell counter SHALL reset to 0 on each channel change.
REQ-017 i0..i3 SHALL NOT change during SHIFT except on an accepted reload (REQ-023).
REQ-018 After the final dwell cycle of channel 3, with no reload, the FSM SHALL return to IDLE: sel 00, active 0, done 1 for exactly one cycle.
REQ-019 A word SHALL therefore occupy 4*DWELL cycles of active=1.
REQ-020 load_data and load_valid SHALL be ignored when load_ready=0. The upstream holds the word until a transfer occurs.
REQ-021 Outputs SHALL be glitch-free registers. load_ready SHALL be decoded from registered state only, never from load_valid.

Reset
REQ-022 While rst=1 at a rising edge, the next cycle SHALL show: state IDLE, i0..i3=0, sel0=sel1=0, active=0, last=0, done=0, dwell counter 0. load_ready SHALL be 0 in any cycle where rst=1 and 1 after release. rst asserted mid-SHIFT SHALL abort the word with no done pulse.

Configuration
REQ-023 With macro PISO_AUTO_RELOAD_EN defined, load_ready SHALL also be 1 during the final dwell cycle of channel 3. A transfer there SHALL load the new word with sel 00 on the next cycle, active staying 1 (zero-gap back-to-back words), and done still pulsing for the completed word.
REQ-024 Without PISO_AUTO_RELOAD_EN, load_ready SHALL be 0 throughout SHIFT. Consecutive words SHALL be separated by at least one IDLE cycle.

Verification
REQ-025 Reset: hold rst=1 for 2 cycles mid-SHIFT -> all outputs 0, load_ready 0 during rst, 1 the cycle after release, no done pulse.
REQ-026 DWELL=1, load 4'b1011 -> i3..i0=1011 held, sel sequence 00,01,10,11 over 4 cycles, last=1 on 4th cycle, then done=1 for one cycle with sel 00. The mux out is 1,1,0,1.
REQ-027 DWELL=3, load 4'b0100 -> each sel value held 3 cycles, active high 12 cycles, done once.
REQ-028 load_valid=1 with load_data changing during SHIFT (macro off) -> i0..i3 unchanged, load_ready 0, next word accepted only in IDLE.
REQ-029 Macro on, DWELL=1, words 4'b1011 then 4'b0100 with load_valid continuously high -> 8 consecutive active cycles, sel 00..11 twice, done pulses in cycle 5 coincident with the second word's sel 00.
REQ-030 Transfer in the same cycle rst deasserts (load_valid=1 during rst) -> no transfer while rst=1, word accepted one cycle after release.
